demux_1_to_2: RTL and testbench

Registered 1-to-2 demultiplexer with per-output routing counters. A data word on `D` is steered to `Y0` when `S`=0 or to `Y1` when `S`=1, and the unselected output is driven to zero. The block sits between a single producer and two consumers, for example when splitting a stream across two downstream lanes. It also keeps saturating counts of words routed to each lane for status and debug.

---
 rtl/demux_1_to_2.sv | 63 ++++++
 tb/tb_demux_1_to_2.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/demux_1_to_2.sv
// Registered 1-to-2 demultiplexer. Each output lane has a saturating count
// of the words routed to it.
module demux_1_to_2 #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     D,
    input  logic                 S,
    input  logic                 in_valid,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     Y0,
    output logic [WIDTH-1:0]     Y1,
    output logic                 y0_valid,
    output logic                 y1_valid,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);

    logic [WIDTH-1:0]     r_y0, r_y1;
    logic                 r_y0_vld, r_y1_vld;
    logic [CNT_WIDTH-1:0] r_cnt0, r_cnt1;

    logic w_sel0, w_sel1;

    assign w_sel0 = in_valid & ~S;
    assign w_sel1 = in_valid &  S;

    // The unselected lane is forced to zero rather than holding its last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y0     <= '0;
            r_y1     <= '0;
            r_y0_vld <= 1'b0;
            r_y1_vld <= 1'b0;
        end else begin
            r_y0     <= w_sel0 ? D : '0;
            r_y1     <= w_sel1 ? D : '0;
            r_y0_vld <= w_sel0;
            r_y1_vld <= w_sel1;
        end
    end

    // A clear beats a same-cycle increment, so the routed word is not counted.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_sel0 && !(&r_cnt0)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_sel1 && !(&r_cnt1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign Y0       = r_y0;
    assign Y1       = r_y1;
    assign y0_valid = r_y0_vld;
    assign y1_valid = r_y1_vld;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

endmodule

// File: tb/tb_demux_1_to_2.sv
// Directed bench for demux_1_to_2: a 1-bit instance and an 8-bit instance
// share the same control stimulus, and both have 4-bit counters.
module tb_demux_1_to_2;

    logic       clk = 1'b0;
    logic       rst, s, in_valid, cnt_clr;
    logic [7:0] d8;
    logic [0:0] d1;

    logic [0:0] a_y0, a_y1;
    logic       a_v0, a_v1;
    logic [3:0] a_c0, a_c1;
    logic [7:0] b_y0, b_y1;
    logic       b_v0, b_v1;
    logic [3:0] b_c0, b_c1;

    int n_chk = 0;
    int n_err = 0;

    assign d1 = d8[0];

    always #5 clk = ~clk;

    demux_1_to_2 #(.WIDTH(1), .CNT_WIDTH(4)) u_w1 (
        .clk(clk), .rst(rst), .D(d1), .S(s), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .Y0(a_y0), .Y1(a_y1), .y0_valid(a_v0), .y1_valid(a_v1), .cnt0(a_c0), .cnt1(a_c1)
    );

    demux_1_to_2 #(.WIDTH(8), .CNT_WIDTH(4)) u_w8 (
        .clk(clk), .rst(rst), .D(d8), .S(s), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .Y0(b_y0), .Y1(b_y1), .y0_valid(b_v0), .y1_valid(b_v1), .cnt0(b_c0), .cnt1(b_c1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [7:0] dat, input logic clr);
        in_valid = v;
        s        = sel;
        d8       = dat;
        cnt_clr  = clr;
        tick();
    endtask

    // Expected state of the 1-bit instance.
    task automatic chk_a(input string tag, input logic y0, input logic y1,
                         input logic v0, input logic v1, input logic [3:0] c0, input logic [3:0] c1);
        chk({tag, ".a_y0"}, 32'(a_y0), 32'(y0));
        chk({tag, ".a_y1"}, 32'(a_y1), 32'(y1));
        chk({tag, ".a_v0"}, 32'(a_v0), 32'(v0));
        chk({tag, ".a_v1"}, 32'(a_v1), 32'(v1));
        chk({tag, ".a_c0"}, 32'(a_c0), 32'(c0));
        chk({tag, ".a_c1"}, 32'(a_c1), 32'(c1));
    endtask

    // Expected state of the 8-bit instance.
    task automatic chk_b(input string tag, input logic [7:0] y0, input logic [7:0] y1,
                         input logic v0, input logic v1, input logic [3:0] c0, input logic [3:0] c1);
        chk({tag, ".b_y0"}, 32'(b_y0), 32'(y0));
        chk({tag, ".b_y1"}, 32'(b_y1), 32'(y1));
        chk({tag, ".b_v0"}, 32'(b_v0), 32'(v0));
        chk({tag, ".b_v1"}, 32'(b_v1), 32'(v1));
        chk({tag, ".b_c0"}, 32'(b_c0), 32'(c0));
        chk({tag, ".b_c1"}, 32'(b_c1), 32'(c1));
    endtask

    initial begin
        // Reset held for two cycles with a valid word present.
        rst = 1'b1; in_valid = 1'b1; s = 1'b0; d8 = 8'h01; cnt_clr = 1'b0;
        tick();
        chk_a("rst1", 0, 0, 0, 0, 0, 0);
        chk_b("rst1", 0, 0, 0, 0, 0, 0);
        tick();
        chk_a("rst2", 0, 0, 0, 0, 0, 0);
        chk_b("rst2", 0, 0, 0, 0, 0, 0);

        rst = 1'b0;
        drive(1, 1, 8'h01, 0);
        chk_a("post_rst", 0, 1, 0, 1, 0, 1);
        chk_b("post_rst", 8'h00, 8'h01, 0, 1, 0, 1);

        drive(0, 0, 8'h00, 1);
        chk_a("clr0", 0, 0, 0, 0, 0, 0);

        // Truth table, one vector per cycle.
        drive(1, 0, 8'h01, 0);
        chk_a("tt_d1s0", 1, 0, 1, 0, 1, 0);
        drive(1, 1, 8'h01, 0);
        chk_a("tt_d1s1", 0, 1, 0, 1, 1, 1);
        drive(1, 0, 8'h00, 0);
        chk_a("tt_d0s0", 0, 0, 1, 0, 2, 1);
        chk_b("tt_d0s0", 8'h00, 8'h00, 1, 0, 2, 1);
        drive(1, 1, 8'h00, 0);
        chk_a("tt_d0s1", 0, 0, 0, 1, 2, 2);
        chk_b("tt_d0s1", 8'h00, 8'h00, 0, 1, 2, 2);

        // One word then three idle cycles: no hold, counters frozen.
        drive(1, 0, 8'h5A, 0);
        chk_b("idle_word", 8'h5A, 8'h00, 1, 0, 3, 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, i[0], 8'hFF, 0);
            chk_a($sformatf("idle%0d", i), 0, 0, 0, 0, 3, 2);
            chk_b($sformatf("idle%0d", i), 8'h00, 8'h00, 0, 0, 3, 2);
        end

        // Saturation of the 4-bit counters.
        drive(0, 0, 8'h00, 1);
        for (int i = 1; i <= 20; i++) begin
            drive(1, 0, 8'(i), 0);
            if (i == 14 || i == 15 || i == 16 || i == 20) begin
                chk($sformatf("sat%0d.b_c0", i), 32'(b_c0), (i > 15) ? 32'd15 : 32'(i));
                chk($sformatf("sat%0d.a_c0", i), 32'(a_c0), (i > 15) ? 32'd15 : 32'(i));
                chk($sformatf("sat%0d.b_c1", i), 32'(b_c1), 32'd0);
            end
        end

        // Clear wins over a same-cycle increment; routing still happens.
        drive(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) drive(1, 0, 8'h11, 0);
        chk("pre_clr.b_c0", 32'(b_c0), 32'd5);
        drive(1, 0, 8'h01, 1);
        chk_a("clr_prio", 1, 0, 1, 0, 0, 0);
        chk_b("clr_prio", 8'h01, 8'h00, 1, 0, 0, 0);

        // Alternating lanes with back-to-back valids.
        drive(0, 0, 8'h00, 1);
        drive(1, 0, 8'hA5, 0);
        chk_b("alt0", 8'hA5, 8'h00, 1, 0, 1, 0);
        drive(1, 1, 8'h3C, 0);
        chk_b("alt1", 8'h00, 8'h3C, 0, 1, 1, 1);
        drive(1, 0, 8'hFF, 0);
        chk_b("alt2", 8'hFF, 8'h00, 1, 0, 2, 1);
        chk_a("alt2", 1, 0, 1, 0, 2, 1);

        // Reset mid-stream overrides valid and clear.
        rst = 1'b1;
        drive(1, 1, 8'h77, 1);
        chk_b("rst_mid", 8'h00, 8'h00, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 8'h00, 0);
        chk_b("rst_rel", 8'h00, 8'h00, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
